line_buffer_ctrl: RTL and testbench
===================================

# line_buffer_ctrl

Streaming two-line buffer for the Sobel datapath. Accepts one pixel per handshake in raster order and emits a vertical 3-tap column (current row, row−1, row−2) for the same column index. It is the write/read master for a single instance of the dual-read-port `sync_ram_block`, and feeds the 3x3 window shifter downstream.

## Interface
- `PIX_W`, 8, pixel width in bits
- `LINE_W`, 640, pixels per line (≥2)
- `clk_i`  in  1  clock
- `rstn_i`  in  1  asynchronous active-low reset
- `sof_i`  in  1  start of frame, qualified by `valid_i`; marks column 0 of line 0
- `valid_i`  in  1  input pixel valid
- `ready_o`  out  1  input ready
- `pix_i`  in  PIX_W  input pixel
- `valid_o`  out  1  output column valid
- `ready_i`  in  1  downstream ready
- `tap0_o`  out  PIX_W  current-row pixel
- `tap1_o`  out  PIX_W  row−1 pixel, same column
- `tap2_o`  out  PIX_W  row−2 pixel, same column
- `col_o`  out  $clog2(LINE_W)  column index of output
- `win_ok_o`  out  1  high when row−1 and row−2 both belong to the current frame

## Operation
- Accept: `acc = valid_i & ready_o`. `ready_o = ~valid_o | ready_i`, a single-stage pipeline with no skid.
- RAM address is `{slot, col}`, with RAM depth `2**($clog2(LINE_W)+1)`. `slot` is the line parity.
- On `acc`, the following happen in the same cycle:
  - Write `pix_i` to `{slot, col}`.
  - Port B reads `{slot, col}`. The RAM is read-first, so port B returns row−2.
  - Port A reads `{~slot, col}`, which returns row−1.
- `rd_en_a/b` and `wr_en` are asserted only on `acc`. RAM read data holds while `rd_en` is low, so the taps are stable during stall.
- Column counter: increments on `acc`. At `LINE_W-1` it wraps to 0, toggles `slot`, and advances the line FSM.
- `sof_i` on an accepted pixel behaves as follows:
  - Forces `col=0`, `slot=0`, and FSM=`FILL0` for that pixel.
  - The next pixel goes to `col=1`.
  - A `sof_i` in mid-line truncates the line.
- Line FSM:
  - `FILL0` (line 0): moves to `FILL1` at end of line.
  - `FILL1` (line 1): moves to `STREAM` at end of line.
  - `STREAM`: holds until `sof_i` or reset.
- `win_ok_o` is registered with the taps. It is 1 only for pixels accepted in `STREAM`.
- `tap0_o` and `col_o` are registered copies of `pix_i` and `col`, loaded on `acc`.

## Timing
- Latency: a pixel accepted at edge N appears at `valid_o` after edge N, together with its taps.
- Throughput: 1 pixel/cycle when `ready_i` is held high.
- `valid_o` behaviour:
  - Set on `acc`.
  - Cleared on `ready_i & ~acc`.
  - Stays high under `ready_i & acc`.
- Outputs are held unchanged while `valid_o & ~ready_i`.
- Reset values:
  - `valid_o=0`, `tap*_o=0`, `col_o=0`, `win_ok_o=0`.
  - Internal state: `col=0`, `slot=0`, FSM=`FILL0`.
  - `ready_o` is 1 one cycle after reset deassertion.
- Reset mid-frame clears all of the above immediately. RAM contents are not cleared; they are masked by FSM=`FILL0`.
- Simultaneous `sof_i` and column wrap: `sof_i` wins.

## Configuration
- `LINE_BUF_BORDER_ZERO_EN` defined:
  - `tap1_o` is forced to 0 for pixels accepted in `FILL0`.
  - `tap2_o` is forced to 0 for pixels accepted in `FILL0` or `FILL1`.
  - Gives a zero top border.
- Not defined: `tap1_o`/`tap2_o` pass raw RAM data. Stale data from the previous frame is possible; only `win_ok_o` qualifies the taps.

## Structure
- `sobel_pkg`: default `PIX_W`/`LINE_W` constants, and the `line_state_e` enum (`FILL0`, `FILL1`, `STREAM`).
- One sub-module: `sync_ram_block` with `WIDTH_P=PIX_W` and `DEPTH_P=2**($clog2(LINE_W)+1)`.
- Controller logic stays in `line_buffer_ctrl`.

## Test plan
All scenarios use `LINE_W=4` and `PIX_W=8`.
- Reset then `sof_i`, then stream 0..11 with `ready_i=1` → outputs appear 1 cycle after accept:
  - Pixel 8: taps (8, 4, 0), `win_ok_o=1`.
  - Pixel 11: taps (11, 7, 3), `col_o=3`.
- Same stream, line 0 and line 1 with the macro defined → `tap1_o=0` on pixels 0–3, `tap2_o=0` on pixels 0–7, `win_ok_o=0` on pixels 0–7.
- Hold `ready_i=0` for 3 cycles while `valid_o=1` → `ready_o=0`, all outputs unchanged, no RAM write. Resume and confirm no pixel is lost or duplicated.
- `sof_i` on the 3rd pixel of line 2 → `col_o=0` on that pixel, `win_ok_o=0`, FSM returns to `FILL0`.
- Assert `rstn_i=0` mid line 2 → `valid_o`/`col_o`/`win_ok_o` go to 0 without waiting for a clock edge. After reset, 12 fresh pixels 100..111 give pixel 108 taps (108, 104, 100).
- Stream 3 full frames back-to-back with random `valid_i`/`ready_i` gaps → every output matches the scoreboard model of taps/col/win_ok.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel datapath.
// Line-buffer build option: LINE_BUF_BORDER_ZERO_EN (zero top border on taps).
package sobel_pkg;

    localparam int DEF_PIX_W  = 8;
    localparam int DEF_LINE_W = 640;

    // Line fill progress of the two-line buffer within the current frame.
    typedef enum logic [1:0] {
        FILL0  = 2'd0,
        FILL1  = 2'd1,
        STREAM = 2'd2
    } line_state_e;

    // Advance the line state at the end of a full line.
    function automatic line_state_e next_line_state(input line_state_e s);
        case (s)
            FILL0:   return FILL1;
            FILL1:   return STREAM;
            default: return STREAM;
        endcase
    endfunction

endpackage

// File: rtl/line_buffer_ctrl_if.sv
// Pixel-in / column-out stream bundle of the line buffer.
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both high; a source holds valid and its payload stable until that edge, and
// ready may depend combinationally on the sink's own state and downstream ready.
interface line_buffer_ctrl_if #(
    parameter int PIX_W  = 8,
    parameter int LINE_W = 640
);
    localparam int COL_W = $clog2(LINE_W);

    logic             sof_i;
    logic             valid_i;
    logic             ready_o;
    logic [PIX_W-1:0] pix_i;
    logic             valid_o;
    logic             ready_i;
    logic [PIX_W-1:0] tap0_o;
    logic [PIX_W-1:0] tap1_o;
    logic [PIX_W-1:0] tap2_o;
    logic [COL_W-1:0] col_o;
    logic             win_ok_o;

    // Line buffer side.
    modport slave (
        input  sof_i, valid_i, pix_i, ready_i,
        output ready_o, valid_o, tap0_o, tap1_o, tap2_o, col_o, win_ok_o
    );

    // Pixel source / column sink side.
    modport master (
        output sof_i, valid_i, pix_i, ready_i,
        input  ready_o, valid_o, tap0_o, tap1_o, tap2_o, col_o, win_ok_o
    );

endinterface

// File: rtl/sync_ram_block.sv
// Single write port, two read ports, read-first; read data registers hold
// their value while their read enable is low.
module sync_ram_block #(
    parameter int WIDTH_P = 8,
    parameter int DEPTH_P = 2048
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH_P)-1:0] wr_addr,
    input  logic [WIDTH_P-1:0]         wr_data,
    input  logic                       rd_en_a,
    input  logic [$clog2(DEPTH_P)-1:0] rd_addr_a,
    output logic [WIDTH_P-1:0]         rd_data_a,
    input  logic                       rd_en_b,
    input  logic [$clog2(DEPTH_P)-1:0] rd_addr_b,
    output logic [WIDTH_P-1:0]         rd_data_b
);

    logic [WIDTH_P-1:0] mem [DEPTH_P];

    // Storage array write; contents are never cleared.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read registers sample the pre-write contents and hold when not enabled.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            if (rd_en_a) rd_data_a <= mem[rd_addr_a];
            if (rd_en_b) rd_data_b <= mem[rd_addr_b];
        end
    end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Streaming two-line buffer: emits (row, row-1, row-2) per column.
// Build option LINE_BUF_BORDER_ZERO_EN zeroes tap1/tap2 during line fill.
module line_buffer_ctrl
    import sobel_pkg::*;
#(
    parameter int PIX_W  = DEF_PIX_W,
    parameter int LINE_W = DEF_LINE_W
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    line_buffer_ctrl_if.slave   bus,
    output line_state_e         state_o
);

    localparam int COL_W  = $clog2(LINE_W);
    localparam int ADDR_W = COL_W + 1;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_W - 1);

    line_state_e      state_q;
    logic [COL_W-1:0] col_q;
    logic             slot_q;
    logic             rst_done_q;
    logic             valid_q;
    logic [PIX_W-1:0] tap0_q;
    logic [COL_W-1:0] col_out_q;
    logic             win_ok_q;
    logic [PIX_W-1:0] rd_data_a;
    logic [PIX_W-1:0] rd_data_b;

    logic             acc;
    logic [COL_W-1:0] eff_col;
    logic             eff_slot;
    line_state_e      eff_state;

    assign acc         = bus.valid_i & bus.ready_o;
    assign bus.ready_o = rst_done_q & (~valid_q | bus.ready_i);

    // A start-of-frame pixel behaves as column 0 of line 0 in slot 0.
    always_comb begin
        eff_col   = col_q;
        eff_slot  = slot_q;
        eff_state = state_q;
        if (bus.sof_i) begin
            eff_col   = '0;
            eff_slot  = 1'b0;
            eff_state = FILL0;
        end
    end

    // Port B reads the slot being overwritten (row-2), port A the other slot (row-1).
    sync_ram_block #(
        .WIDTH_P (PIX_W),
        .DEPTH_P (DEPTH)
    ) u_ram (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .wr_en     (acc),
        .wr_addr   ({eff_slot, eff_col}),
        .wr_data   (bus.pix_i),
        .rd_en_a   (acc),
        .rd_addr_a ({~eff_slot, eff_col}),
        .rd_data_a (rd_data_a),
        .rd_en_b   (acc),
        .rd_addr_b ({eff_slot, eff_col}),
        .rd_data_b (rd_data_b)
    );

    // Column counter, line parity, line FSM and the output register stage.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= FILL0;
            col_q      <= '0;
            slot_q     <= 1'b0;
            rst_done_q <= 1'b0;
            valid_q    <= 1'b0;
            tap0_q     <= '0;
            col_out_q  <= '0;
            win_ok_q   <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            if (acc) begin
                valid_q   <= 1'b1;
                tap0_q    <= bus.pix_i;
                col_out_q <= eff_col;
                win_ok_q  <= (eff_state == STREAM);
                if (eff_col == LAST_COL) begin
                    col_q   <= '0;
                    slot_q  <= ~eff_slot;
                    state_q <= next_line_state(eff_state);
                end else begin
                    col_q   <= eff_col + 1'b1;
                    slot_q  <= eff_slot;
                    state_q <= eff_state;
                end
            end else if (bus.ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef LINE_BUF_BORDER_ZERO_EN
    logic zero1_q;
    logic zero2_q;

    // Remember which taps lie above the top of the frame for the held pixel.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            zero1_q <= 1'b0;
            zero2_q <= 1'b0;
        end else if (acc) begin
            zero1_q <= (eff_state == FILL0);
            zero2_q <= (eff_state != STREAM);
        end
    end

    assign bus.tap1_o = zero1_q ? '0 : rd_data_a;
    assign bus.tap2_o = zero2_q ? '0 : rd_data_b;
`else
    assign bus.tap1_o = rd_data_a;
    assign bus.tap2_o = rd_data_b;
`endif

    assign bus.valid_o  = valid_q;
    assign bus.tap0_o   = tap0_q;
    assign bus.col_o    = col_out_q;
    assign bus.win_ok_o = win_ok_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Self-checking bench for line_buffer_ctrl with LINE_W=4, PIX_W=8.
// Honours LINE_BUF_BORDER_ZERO_EN when defined.
module tb_line_buffer_ctrl;
    import sobel_pkg::*;

    localparam int PIX_W  = 8;
    localparam int LINE_W = 4;
    localparam int COL_W  = 2;

    logic clk_i  = 1'b0;
    logic rstn_i = 1'b0;

    line_buffer_ctrl_if #(.PIX_W(PIX_W), .LINE_W(LINE_W)) bus ();
    line_state_e state_o;

    line_buffer_ctrl #(.PIX_W(PIX_W), .LINE_W(LINE_W)) dut (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .bus     (bus.slave),
        .state_o (state_o)
    );

    // Clock.
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [PIX_W-1:0] tap0;
        logic [PIX_W-1:0] tap1;
        logic [PIX_W-1:0] tap2;
        logic [COL_W-1:0] col;
        logic             win_ok;
        logic             chk1;
        logic             chk2;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: last two rows seen per column, plus line position.
    logic [PIX_W-1:0] row_m1 [LINE_W];
    logic [PIX_W-1:0] row_m2 [LINE_W];
    int m_col  = 0;
    int m_line = 0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_col  = 0;
        m_line = 0;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic [PIX_W-1:0] pix, input logic sof);
        exp_t e;
        if (sof) begin
            m_col  = 0;
            m_line = 0;
        end
        e.tap0   = pix;
        e.col    = COL_W'(m_col);
        e.win_ok = (m_line >= 2);
`ifdef LINE_BUF_BORDER_ZERO_EN
        e.tap1 = (m_line == 0) ? '0 : row_m1[m_col];
        e.tap2 = (m_line <= 1) ? '0 : row_m2[m_col];
        e.chk1 = 1'b1;
        e.chk2 = 1'b1;
`else
        e.tap1 = row_m1[m_col];
        e.tap2 = row_m2[m_col];
        e.chk1 = (m_line >= 1);
        e.chk2 = (m_line >= 2);
`endif
        exp_q.push_back(e);
        row_m2[m_col] = row_m1[m_col];
        row_m1[m_col] = pix;
        m_col++;
        if (m_col == LINE_W) begin
            m_col = 0;
            if (m_line < 2) m_line++;
        end
    endtask

    task automatic compare_out(input exp_t e);
        check_eq("tap0", 32'(bus.tap0_o), 32'(e.tap0));
        check_eq("col", 32'(bus.col_o), 32'(e.col));
        check_eq("win_ok", 32'(bus.win_ok_o), 32'(e.win_ok));
        if (e.chk1) check_eq("tap1", 32'(bus.tap1_o), 32'(e.tap1));
        if (e.chk2) check_eq("tap2", 32'(bus.tap2_o), 32'(e.tap2));
    endtask

    // Drive one cycle at the falling edge, score outputs, then cross the rising edge.
    task automatic one_cycle(input logic v, input logic [PIX_W-1:0] p, input logic s,
                             input logic r, output logic accepted);
        exp_t e;
        @(negedge clk_i);
        bus.valid_i = v;
        bus.pix_i   = p;
        bus.sof_i   = s;
        bus.ready_i = r;
        #1;
        check_eq("state", 32'(state_o), 32'(m_line));
        if (bus.valid_o) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_valid", 32'(bus.valid_o), 32'd0);
            end else if (bus.ready_i) begin
                e = exp_q.pop_front();
                compare_out(e);
            end else begin
                compare_out(exp_q[0]);
            end
        end
        accepted = v & bus.ready_o;
        if (accepted) model_accept(p, s);
        @(posedge clk_i);
    endtask

    task automatic stream_seq(input int first, input int count, input logic sof_first);
        logic a;
        for (int i = 0; i < count; i++) begin
            one_cycle(1'b1, PIX_W'(first + i), sof_first && (i == 0), 1'b1, a);
            if (!a) check_eq("stream_accept", 32'(a), 32'd1);
        end
    endtask

    task automatic drain();
        logic a;
        int n = 0;
        while ((exp_q.size() != 0 || bus.valid_o) && n < 20) begin
            one_cycle(1'b0, '0, 1'b0, 1'b1, a);
            n++;
        end
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic a;
        logic held;
        bus.valid_i = 1'b0;
        bus.pix_i   = '0;
        bus.sof_i   = 1'b0;
        bus.ready_i = 1'b0;
        for (int i = 0; i < LINE_W; i++) begin
            row_m1[i] = '0;
            row_m2[i] = '0;
        end

        // Reset state.
        #2;
        check_eq("rst_valid", 32'(bus.valid_o), 32'd0);
        check_eq("rst_ready", 32'(bus.ready_o), 32'd0);
        check_eq("rst_tap0", 32'(bus.tap0_o), 32'd0);
        check_eq("rst_tap1", 32'(bus.tap1_o), 32'd0);
        check_eq("rst_tap2", 32'(bus.tap2_o), 32'd0);
        check_eq("rst_col", 32'(bus.col_o), 32'd0);
        check_eq("rst_win", 32'(bus.win_ok_o), 32'd0);
        check_eq("rst_state", 32'(state_o), 32'(FILL0));
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        #1;
        check_eq("ready_before_edge", 32'(bus.ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        check_eq("ready_after_edge", 32'(bus.ready_o), 32'd1);

        // Basic frame: 0..11 with sof.
        stream_seq(0, 12, 1'b1);
        drain();

        // Stall for 3 cycles mid-stream with a bogus pixel offered.
        stream_seq(0, 9, 1'b1);
        for (int k = 0; k < 3; k++) begin
            one_cycle(1'b1, 8'hEE, 1'b0, 1'b0, a);
            check_eq("stall_ready", 32'(a), 32'd0);
        end
        stream_seq(9, 7, 1'b0);
        drain();

        // sof on the third pixel of line 2.
        stream_seq(20, 10, 1'b1);
        stream_seq(40, 6, 1'b1);
        #2;
        check_eq("sof_state", 32'(state_o), 32'(FILL1));
        drain();

        // Asynchronous reset in the middle of line 2.
        stream_seq(50, 10, 1'b1);
        @(negedge clk_i);
        #2;
        check_eq("pre_rst_valid", 32'(bus.valid_o), 32'd1);
        rstn_i = 1'b0;
        #1;
        check_eq("arst_valid", 32'(bus.valid_o), 32'd0);
        check_eq("arst_col", 32'(bus.col_o), 32'd0);
        check_eq("arst_win", 32'(bus.win_ok_o), 32'd0);
        check_eq("arst_state", 32'(state_o), 32'(FILL0));
        model_reset();
        bus.valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i);
        stream_seq(100, 12, 1'b0);
        drain();

        // Three frames with random source and sink gaps.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 4 * LINE_W; i++) begin
                held = 1'b0;
                for (int t = 0; t < 50; t++) begin
                    logic v;
                    v = held | ($urandom_range(0, 3) != 0);
                    one_cycle(v, PIX_W'($urandom_range(0, 255)) ^ PIX_W'(0), (i == 0),
                              ($urandom_range(0, 3) != 0), a);
                    held = v;
                    if (a) break;
                    if (t == 49) check_eq("rand_accept_timeout", 32'(a), 32'd1);
                end
            end
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
